mips_mc_ctrl: RTL

- Multicycle control FSM for the word-addressable MIPS core.
- Sequences the PC, instruction register, register file, ALU muxes and shared instruction/data memory, one instruction at a time.
- Drives the PC next-address select {PCSrc,Branch} plus a PC write enable.
- Waits on a memory-ready handshake, with a bounded timeout.

---
 rtl/mips_ctrl_pkg.sv | 43 ++++
 rtl/mem_wait_timer.sv | 38 +++
 rtl/mips_mc_ctrl.sv | 170 +++++++++++++++++
 3 files changed

// File: rtl/mips_ctrl_pkg.sv
// Shared encodings for the multicycle MIPS control FSM.
// State enum, opcode/pc_src/ALU encodings and the wait-state predicate.
package mips_ctrl_pkg;

  typedef enum logic [3:0] {
    FETCH,
    DECODE,
    MEMADR,
    MEMRD,
    MEMWB,
    MEMWR,
    EXEC,
    ALUWB,
    ADDIEX,
    ADDIWB,
    BRANCH,
    JUMP
  } state_e;

  localparam logic [5:0] OP_R    = 6'b000000;
  localparam logic [5:0] OP_LW   = 6'b100011;
  localparam logic [5:0] OP_SW   = 6'b101011;
  localparam logic [5:0] OP_BEQ  = 6'b000100;
  localparam logic [5:0] OP_ADDI = 6'b001000;
  localparam logic [5:0] OP_J    = 6'b000010;

  localparam logic [1:0] PCS_INC = 2'b00;
  localparam logic [1:0] PCS_BR  = 2'b01;
  localparam logic [1:0] PCS_JMP = 2'b10;

  localparam logic [1:0] ALU_ADD   = 2'b00;
  localparam logic [1:0] ALU_SUB   = 2'b01;
  localparam logic [1:0] ALU_FUNCT = 2'b10;

  localparam logic [1:0] SRCB_RT  = 2'b00;
  localparam logic [1:0] SRCB_ONE = 2'b01;
  localparam logic [1:0] SRCB_IMM = 2'b10;

  function automatic logic is_wait_state(input state_e s);
    return (s == FETCH) || (s == MEMRD) || (s == MEMWR);
  endfunction

endpackage

// File: rtl/mem_wait_timer.sv
// Counts consecutive memory-wait cycles; expire flags the last allowed cycle without ready.
// Combinational expire, counter updates next edge; no backpressure of its own.
module mem_wait_timer #(
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic in_wait,
  input  logic ready,
  input  logic clear,
  output logic expire
);

  localparam int CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  assign expire = in_wait && !ready && (cnt_q == CNT_LAST);

  always_comb begin
    cnt_d = cnt_q;
    if (clear || ready || expire || !in_wait) begin
      cnt_d = '0;
    end else begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/mips_mc_ctrl.sv
// Multicycle MIPS control FSM: Moore strobes per state, memory waits bounded by a timeout.
// R/ADDI/SW 4 cycles, LW 5, BEQ/J 3 with mem_ready high; stalls in FETCH/MEMRD/MEMWR on !mem_ready.
module mips_mc_ctrl
  import mips_ctrl_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [5:0] opcode,
  input  logic       zero,
  input  logic       mem_ready,
  output logic       pc_we,
  output logic [1:0] pc_src,
  output logic       ir_we,
  output logic       mem_re,
  output logic       mem_we,
  output logic       iord,
  output logic       reg_we,
  output logic       reg_dst,
  output logic       mem_to_reg,
  output logic       alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [1:0] alu_op,
  output logic       retire,
  output logic       illegal,
  output logic       bus_err
);

  state_e state_q, state_d;
  logic   wait_exp;

  mem_wait_timer #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_timer (
    .clk    (clk),
    .rst    (rst),
    .in_wait(is_wait_state(state_q)),
    .ready  (mem_ready),
    .clear  (state_d != state_q),
    .expire (wait_exp)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= FETCH;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    pc_we      = 1'b0;
    pc_src     = PCS_INC;
    ir_we      = 1'b0;
    mem_re     = 1'b0;
    mem_we     = 1'b0;
    iord       = 1'b0;
    reg_we     = 1'b0;
    reg_dst    = 1'b0;
    mem_to_reg = 1'b0;
    alu_src_a  = 1'b0;
    alu_src_b  = SRCB_RT;
    alu_op     = ALU_ADD;
    retire     = 1'b0;
    illegal    = 1'b0;
    bus_err    = 1'b0;
    // Reset wins over everything, so an interrupted access never reports an error.
    if (!rst) begin
      unique case (state_q)
        FETCH: begin
          mem_re    = 1'b1;
          alu_src_b = SRCB_ONE;
          if (mem_ready) begin
            ir_we   = 1'b1;
            pc_we   = 1'b1;
            state_d = DECODE;
          end else if (wait_exp) begin
            bus_err = 1'b1;
          end
        end
        DECODE: begin
          unique case (opcode)
            OP_LW, OP_SW: state_d = MEMADR;
            OP_R:         state_d = EXEC;
            OP_ADDI:      state_d = ADDIEX;
            OP_BEQ:       state_d = BRANCH;
            OP_J:         state_d = JUMP;
            default: begin
              illegal = 1'b1;
              state_d = FETCH;
            end
          endcase
        end
        MEMADR: begin
          alu_src_a = 1'b1;
          alu_src_b = SRCB_IMM;
          if (opcode == OP_LW)      state_d = MEMRD;
          else if (opcode == OP_SW) state_d = MEMWR;
          else                      state_d = FETCH;
        end
        MEMRD: begin
          mem_re = 1'b1;
          iord   = 1'b1;
          if (mem_ready) begin
            state_d = MEMWB;
          end else if (wait_exp) begin
            bus_err = 1'b1;
            state_d = FETCH;
          end
        end
        MEMWB: begin
          reg_we     = 1'b1;
          mem_to_reg = 1'b1;
          retire     = 1'b1;
          state_d    = FETCH;
        end
        MEMWR: begin
          mem_we = 1'b1;
          iord   = 1'b1;
          if (mem_ready) begin
            retire  = 1'b1;
            state_d = FETCH;
          end else if (wait_exp) begin
            bus_err = 1'b1;
            state_d = FETCH;
          end
        end
        EXEC: begin
          alu_src_a = 1'b1;
          alu_op    = ALU_FUNCT;
          state_d   = ALUWB;
        end
        ALUWB: begin
          reg_we  = 1'b1;
          reg_dst = 1'b1;
          retire  = 1'b1;
          state_d = FETCH;
        end
        ADDIEX: begin
          alu_src_a = 1'b1;
          alu_src_b = SRCB_IMM;
          state_d   = ADDIWB;
        end
        ADDIWB: begin
          reg_we  = 1'b1;
          retire  = 1'b1;
          state_d = FETCH;
        end
        BRANCH: begin
          alu_src_a = 1'b1;
          alu_op    = ALU_SUB;
          pc_src    = PCS_BR;
          pc_we     = zero;
          retire    = 1'b1;
          state_d   = FETCH;
        end
        JUMP: begin
          pc_src  = PCS_JMP;
          pc_we   = 1'b1;
          retire  = 1'b1;
          state_d = FETCH;
        end
        default: state_d = FETCH;
      endcase
    end
  end

endmodule
